phy_tx_lane_serializer: RTL and testbench
=========================================

// Module: phy_tx_lane_serializer
// PURPOSE
//  Parametrised N-lane to 1-lane PCIe PHY transmit serializer on a single clock.
//  Replaces the multi-clock tree of 2:1 byte muxes. One word of LANES x DATA_W
//  bytes, with a per-lane valid mask, is loaded at a time.
//  Lanes are emitted one per clk, lane 0 first. A one-word shadow buffer gives
//  gap-free streaming into the serial PHY stage.
// PARAMETERS
//  LANES         4  number of input lanes (>=2); lane index width = $clog2(LANES)
//  DATA_W        8  bits per lane/slot
//  SKIP_INVALID  0  0: emit every lane slot; 1: emit only valid lanes (compacted)
// PORTS
//  clk            in   1              single transmit clock, rising edge
//  reset          in   1              asynchronous, active-high
//  in_data        in   LANES*DATA_W   lane i = in_data[i*DATA_W +: DATA_W]
//  in_lane_valid  in   LANES          per-lane valid mask for in_data
//  in_load        in   1              load request; accepted when in_load && in_ready
//  in_ready       out  1              1 = shadow buffer empty, load can be accepted
//  data_out       out  DATA_W         serialized byte (registered)
//  valid_out      out  1              data_out carries a valid lane byte
//  frame_start    out  1              high with first emitted slot of each word
//  busy           out  1              active or shadow word pending
// BEHAVIOUR
//  - Reset (async, immediate): data_out=0, valid_out=0, frame_start=0, busy=0, in_ready=1.
//    Active and shadow buffers are emptied and the lane index is set to 0.
//    A partially sent word is discarded; emission restarts only after a new load.
//  - Storage: active word, lane index and active_v; shadow word and shadow_v.
//    in_ready = !shadow_v. busy = active_v | shadow_v.
//  - Accept at edge k:
//    - If !active_v, or the active word emits its last slot at edge k, the word goes to active.
//    - Otherwise it goes to shadow.
//    - in_load while !in_ready is ignored; nothing is captured.
//  - Latency: word accepted at edge k while idle -> first slot on data_out after edge k+1.
//  - Slot emission, SKIP_INVALID=0: lane i registered at edge k+1+i, i=0..LANES-1.
//    valid_out = in_lane_valid[i]; data_out = lane byte if valid, else 0.
//  - Slot emission, SKIP_INVALID=1: only valid lanes are emitted, ascending order,
//    on consecutive edges, all with valid_out=1; slot count = popcount(mask).
//    An all-zero mask is accepted and dropped: no slots, no frame_start, no stall.
//  - When no slot is emitted at an edge: data_out=0, valid_out=0, frame_start=0.
//  - Last slot at edge t with shadow_v=1: shadow moves to active at edge t.
//    The first shadow slot follows at edge t+1 (no bubble); shadow_v clears and in_ready=1.
//  - Shadow empty at that edge with in_load=1: the word loads directly to active.
//    Back-to-back loads therefore give 100% slot utilisation.
//  - Load and shadow drain at the same edge: only possible when the shadow was
//    full, so in_ready=0 and the load is ignored.
//  - frame_start=1 exactly in the cycle data_out carries the first emitted slot of a word.
//  - Lane index wraps from LANES-1 (or the last valid lane) back to 0 per word.
//    No state leaks between words.
// TESTING  (LANES=4, DATA_W=8 unless noted)
//  1. Reset mid-word: assert reset while lane 1 is on data_out.
//     -> all outputs 0 immediately, in_ready=1.
//     -> After release, no output until the next in_load.
//  2. Idle load {A3,B2,C1,D0} (lane0=D0), mask 1111, edge k.
//     -> D0,C1,B2,A3 at edges k+1..k+4 with valid_out=1; frame_start only at k+1.
//  3. SKIP_INVALID=0, mask 0101 with lanes {44,33,22,11}.
//     -> 11/v1, 00/v0, 33/v1, 00/v0.
//     SKIP_INVALID=1, same input -> 11, 33 on consecutive edges, then idle.
//  4. Streaming: in_load held high with 3 words.
//     -> 12 contiguous valid slots, frame_start every 4th cycle.
//     -> in_ready low while the shadow is full; no word lost or duplicated.
//  5. Backpressure: in_load with in_ready=0 and different data.
//     -> ignored; emitted stream is unchanged.
//  6. SKIP_INVALID=1: mask 0000 word then mask 1000 word (lane3=5A) back-to-back.
//     -> the first word is dropped, then 5A with frame_start=1; no extra idle cycle.

Source files
------------

// File: rtl/phy_tx_lane_serializer_if.sv
// Lane-serializer bus bundle.
// Parallel load side: in_data / in_lane_valid / in_load in, in_ready back.
// Serial side: data_out, valid_out, frame_start and busy from the serializer.
// The master modport belongs to the word source and the slave modport to the serializer.
interface phy_tx_lane_serializer_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 8
);
  logic [LANES*DATA_W-1:0] in_data;
  logic [LANES-1:0]        in_lane_valid;
  logic                    in_load;
  logic                    in_ready;
  logic [DATA_W-1:0]       data_out;
  logic                    valid_out;
  logic                    frame_start;
  logic                    busy;

  modport master (
    output in_data, in_lane_valid, in_load,
    input  in_ready, data_out, valid_out, frame_start, busy
  );

  modport slave (
    input  in_data, in_lane_valid, in_load,
    output in_ready, data_out, valid_out, frame_start, busy
  );
endinterface

// File: rtl/phy_tx_lane_serializer.sv
// N-lane to 1-lane PHY transmit serializer on a single clock.
// Each cycle it sends one lane of a loaded word, starting with lane 0.
// A one-word shadow buffer holds the next word, so streaming has no gaps between words.
// Ports:
//   clk    - transmit clock, rising edge
//   reset  - asynchronous, active-high; discards active and shadow words
//   bus    - slave modport of phy_tx_lane_serializer_if:
//            in_data/in_lane_valid/in_load in, in_ready out (shadow empty),
//            data_out/valid_out/frame_start registered, busy = word held.
// SKIP_INVALID=1 sends only valid lanes, packed together, and drops all-zero masks on load.
module phy_tx_lane_serializer #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned SKIP_INVALID = 0
) (
  input logic                      clk,
  input logic                      reset,
  phy_tx_lane_serializer_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(LANES);
  typedef logic [IDX_W-1:0] idx_t;

  logic [LANES*DATA_W-1:0] act_data_q, act_data_d;
  logic [LANES-1:0]        act_mask_q, act_mask_d;
  logic                    act_v_q, act_v_d;
  logic                    first_q, first_d;
  idx_t                    idx_q, idx_d;
  logic [LANES*DATA_W-1:0] sh_data_q, sh_data_d;
  logic [LANES-1:0]        sh_mask_q, sh_mask_d;
  logic                    sh_v_q, sh_v_d;
  logic [DATA_W-1:0]       data_out_q, data_out_d;
  logic                    valid_out_q, valid_out_d;
  logic                    frame_q, frame_d;

  // Returns {found, index} for the lowest set mask bit at or above 'from'.
  function automatic logic [IDX_W:0] next_valid(input logic [LANES-1:0] mask,
                                                input int unsigned from);
    logic found;
    idx_t idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = LANES; i > 0; i--) begin
      if ((i - 1) >= from && mask[i-1]) begin
        found = 1'b1;
        idx   = idx_t'(i - 1);
      end
    end
    return {found, idx};
  endfunction

  logic            skip;
  logic            lane_v;
  logic            last;
  logic            accept;
  logic            in_has;
  logic            free;
  logic [IDX_W:0]  nv;
  logic [IDX_W:0]  first_sh;
  logic [IDX_W:0]  first_in;
  int unsigned     from_nxt;

  always_comb begin
    skip     = (SKIP_INVALID != 0);
    act_data_d  = act_data_q;
    act_mask_d  = act_mask_q;
    act_v_d     = act_v_q;
    first_d     = first_q;
    idx_d       = idx_q;
    sh_data_d   = sh_data_q;
    sh_mask_d   = sh_mask_q;
    sh_v_d      = sh_v_q;
    data_out_d  = '0;
    valid_out_d = 1'b0;
    frame_d     = 1'b0;

    // In compacted mode idx_q always points at a valid lane, so lane_v is 1 there.
    lane_v   = act_mask_q[idx_q];
    from_nxt = idx_q + 1;
    nv       = next_valid(act_mask_q, from_nxt);
    first_sh = next_valid(sh_mask_q, 0);
    first_in = next_valid(bus.in_lane_valid, 0);
    last     = skip ? !nv[IDX_W] : (idx_q == idx_t'(LANES - 1));
    in_has   = !skip || (|bus.in_lane_valid);
    accept   = bus.in_load && !sh_v_q;
    free     = !act_v_q || last;

    if (act_v_q) begin
      data_out_d  = lane_v ? act_data_q[idx_q*DATA_W +: DATA_W] : '0;
      valid_out_d = lane_v;
      frame_d     = first_q;
      first_d     = 1'b0;
      idx_d       = skip ? nv[IDX_W-1:0] : idx_t'(idx_q + 1'b1);
    end

    // When the active word sends its last slot, it is replaced in the same edge.
    // The shadow word is used first. If the shadow is empty, a word being accepted now
    // goes straight to active. If the shadow is full, in_ready is low, so no load is
    // accepted in that edge.
    if (free) begin
      if (sh_v_q) begin
        act_data_d = sh_data_q;
        act_mask_d = sh_mask_q;
        act_v_d    = 1'b1;
        first_d    = 1'b1;
        idx_d      = skip ? first_sh[IDX_W-1:0] : '0;
        sh_v_d     = 1'b0;
      end else if (accept && in_has) begin
        act_data_d = bus.in_data;
        act_mask_d = bus.in_lane_valid;
        act_v_d    = 1'b1;
        first_d    = 1'b1;
        idx_d      = skip ? first_in[IDX_W-1:0] : '0;
      end else begin
        act_v_d = 1'b0;
        first_d = 1'b0;
        idx_d   = '0;
      end
    end else if (accept && in_has) begin
      sh_data_d = bus.in_data;
      sh_mask_d = bus.in_lane_valid;
      sh_v_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_data_q  <= '0;
      act_mask_q  <= '0;
      act_v_q     <= 1'b0;
      first_q     <= 1'b0;
      idx_q       <= '0;
      sh_data_q   <= '0;
      sh_mask_q   <= '0;
      sh_v_q      <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      act_data_q  <= act_data_d;
      act_mask_q  <= act_mask_d;
      act_v_q     <= act_v_d;
      first_q     <= first_d;
      idx_q       <= idx_d;
      sh_data_q   <= sh_data_d;
      sh_mask_q   <= sh_mask_d;
      sh_v_q      <= sh_v_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.frame_start = frame_q;
  assign bus.in_ready    = !sh_v_q;
  assign bus.busy        = act_v_q | sh_v_q;
endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
module tb_phy_tx_lane_serializer;
  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  phy_tx_lane_serializer_if #(.LANES(LANES), .DATA_W(DW)) b0 ();
  phy_tx_lane_serializer_if #(.LANES(LANES), .DATA_W(DW)) b1 ();

  phy_tx_lane_serializer #(.LANES(LANES), .DATA_W(DW), .SKIP_INVALID(0)) dut0 (
    .clk(clk), .reset(rst), .bus(b0)
  );
  phy_tx_lane_serializer #(.LANES(LANES), .DATA_W(DW), .SKIP_INVALID(1)) dut1 (
    .clk(clk), .reset(rst), .bus(b1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          sel;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [39:0] exp_d;  // byte s = expected data_out s+1 edges after the load edge
    logic [4:0]  exp_v;
    logic [4:0]  exp_f;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic [31:0] d, input logic [3:0] m, input logic ld);
    if (sel == 0) begin
      b0.in_data = d; b0.in_lane_valid = m; b0.in_load = ld;
    end else begin
      b1.in_data = d; b1.in_lane_valid = m; b1.in_load = ld;
    end
  endtask

  task automatic chk_out(input int sel, input string tag, input logic [7:0] ed,
                         input logic ev, input logic ef);
    logic [7:0] d;
    logic v, f;
    if (sel == 0) begin
      d = b0.data_out; v = b0.valid_out; f = b0.frame_start;
    end else begin
      d = b1.data_out; v = b1.valid_out; f = b1.frame_start;
    end
    chk({tag, ".data"},  32'(d), 32'(ed));
    chk({tag, ".valid"}, 32'(v), 32'(ev));
    chk({tag, ".frame"}, 32'(f), 32'(ef));
  endtask

  task automatic chk_state(input int sel, input string tag, input logic erdy, input logic ebusy);
    logic r, b;
    r = (sel == 0) ? b0.in_ready : b1.in_ready;
    b = (sel == 0) ? b0.busy     : b1.busy;
    chk({tag, ".in_ready"}, 32'(r), 32'(erdy));
    chk({tag, ".busy"},     32'(b), 32'(ebusy));
  endtask

  initial begin
    logic [31:0] w[3];
    logic [31:0] cw;
    logic        rdy;
    int          j;

    vecs[0] = '{0, 32'hA3B2C1D0, 4'b1111, 40'h00A3B2C1D0, 5'b01111, 5'b00001};
    vecs[1] = '{0, 32'h44332211, 4'b0101, 40'h0000330011, 5'b00101, 5'b00001};
    vecs[2] = '{0, 32'h5A000000, 4'b1000, 40'h005A000000, 5'b01000, 5'b00001};
    vecs[3] = '{1, 32'h44332211, 4'b0101, 40'h0000003311, 5'b00011, 5'b00001};
    vecs[4] = '{1, 32'hA3B2C1D0, 4'b1111, 40'h00A3B2C1D0, 5'b01111, 5'b00001};
    vecs[5] = '{1, 32'h5A000000, 4'b1000, 40'h000000005A, 5'b00001, 5'b00001};
    vecs[6] = '{1, 32'h44332211, 4'b0110, 40'h0000003322, 5'b00011, 5'b00001};

    drive(0, '0, '0, 1'b0);
    drive(1, '0, '0, 1'b0);
    #1 rst = 1'b1;
    #2;
    chk_out(0, "rst0", 8'h00, 1'b0, 1'b0);
    chk_state(0, "rst0", 1'b1, 1'b0);
    chk_out(1, "rst1", 8'h00, 1'b0, 1'b0);
    chk_state(1, "rst1", 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single words loaded while idle
    for (int vi = 0; vi < 7; vi++) begin
      drive(vecs[vi].sel, vecs[vi].data, vecs[vi].mask, 1'b1);
      tick();
      drive(vecs[vi].sel, '0, '0, 1'b0);
      for (int s = 0; s < 5; s++) begin
        tick();
        chk_out(vecs[vi].sel, $sformatf("vec%0d.slot%0d", vi, s),
                vecs[vi].exp_d[s*8 +: 8], vecs[vi].exp_v[s], vecs[vi].exp_f[s]);
      end
      chk_state(vecs[vi].sel, $sformatf("vec%0d.end", vi), 1'b1, 1'b0);
      tick();
    end

    // Reset asserted while lane 1 is on data_out
    drive(0, 32'hA3B2C1D0, 4'b1111, 1'b1);
    tick();
    drive(0, '0, '0, 1'b0);
    tick();
    tick();
    chk_out(0, "mid.pre", 8'hC1, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk_out(0, "mid.rst", 8'h00, 1'b0, 1'b0);
    chk_state(0, "mid.rst", 1'b1, 1'b0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out(0, $sformatf("mid.post%0d", i), 8'h00, 1'b0, 1'b0);
    end

    // Streaming: in_load held high for three words
    w[0] = 32'h13121110;
    w[1] = 32'h23222120;
    w[2] = 32'h33323130;
    j = 0;
    drive(0, w[0], 4'b1111, 1'b1);
    for (int t = 1; t <= 14; t++) begin
      rdy = b0.in_ready;
      tick();
      if (b0.in_load && rdy) j++;
      if (j < 3) drive(0, w[j], 4'b1111, 1'b1);
      else       drive(0, '0, '0, 1'b0);
      if (t >= 2 && t <= 13) begin
        cw = w[(t - 2) / 4];
        chk_out(0, $sformatf("stream.t%0d", t), cw[((t - 2) % 4) * 8 +: 8], 1'b1,
                ((t - 2) % 4) == 0);
      end else begin
        chk_out(0, $sformatf("stream.t%0d", t), 8'h00, 1'b0, 1'b0);
      end
      chk({"stream.rdy", $sformatf("%0d", t)}, 32'(b0.in_ready),
          32'((t == 1) || (t == 5) || (t >= 9)));
    end
    chk("stream.accepted", 32'(j), 32'd3);
    chk("stream.busy_end", 32'(b0.busy), 32'd0);
    tick();

    // Backpressure: loads while in_ready=0 carry different data and must be ignored
    w[0] = 32'hA3B2C1D0;
    w[1] = 32'h17161514;
    drive(0, w[0], 4'b1111, 1'b1);
    tick();
    drive(0, w[1], 4'b1111, 1'b1);
    tick();
    chk_out(0, "bp.e2", 8'hD0, 1'b1, 1'b1);
    drive(0, 32'hEEEEEEEE, 4'b1111, 1'b1);
    for (int e = 3; e <= 5; e++) begin
      chk($sformatf("bp.rdy%0d", e), 32'(b0.in_ready), 32'd0);
      tick();
      cw = w[0];
      chk_out(0, $sformatf("bp.e%0d", e), cw[(e - 2) * 8 +: 8], 1'b1, 1'b0);
    end
    drive(0, '0, '0, 1'b0);
    for (int e = 6; e <= 9; e++) begin
      tick();
      cw = w[1];
      chk_out(0, $sformatf("bp.e%0d", e), cw[(e - 6) * 8 +: 8], 1'b1, e == 6);
    end
    tick();
    chk_out(0, "bp.e10", 8'h00, 1'b0, 1'b0);
    chk_state(0, "bp.end", 1'b1, 1'b0);
    tick();

    // Compacted mode: an all-zero word is dropped, then the next word follows with no stall
    drive(1, 32'h11111111, 4'b0000, 1'b1);
    tick();
    chk_out(1, "zero.e1", 8'h00, 1'b0, 1'b0);
    chk_state(1, "zero.e1", 1'b1, 1'b0);
    drive(1, 32'h5A000000, 4'b1000, 1'b1);
    tick();
    drive(1, '0, '0, 1'b0);
    chk_out(1, "zero.e2", 8'h00, 1'b0, 1'b0);
    chk_state(1, "zero.e2", 1'b1, 1'b1);
    tick();
    chk_out(1, "zero.e3", 8'h5A, 1'b1, 1'b1);
    tick();
    chk_out(1, "zero.e4", 8'h00, 1'b0, 1'b0);
    chk_state(1, "zero.e4", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
